// File: rtl/tick_bcd_timer_if.sv
// Control and display bundle of the two-digit BCD event timer.
// The lap signals exist only when TICK_BCD_TIMER_LAP_EN is defined.
interface tick_bcd_timer_if;
  logic       tick_in;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] bcd_ones;
  logic [3:0] bcd_tens;
  logic       running;
  logic       wrap;
`ifdef TICK_BCD_TIMER_LAP_EN
  logic       lap;
  logic [3:0] lap_ones;
  logic [3:0] lap_tens;

  modport master (
    output tick_in, start, stop, clear, lap,
    input  bcd_ones, bcd_tens, running, wrap, lap_ones, lap_tens
  );

  modport slave (
    input  tick_in, start, stop, clear, lap,
    output bcd_ones, bcd_tens, running, wrap, lap_ones, lap_tens
  );
`else
  modport master (
    output tick_in, start, stop, clear,
    input  bcd_ones, bcd_tens, running, wrap
  );

  modport slave (
    input  tick_in, start, stop, clear,
    output bcd_ones, bcd_tens, running, wrap
  );
`endif
endinterface

// File: rtl/tick_bcd_timer.sv
// Two-digit BCD event timer advanced by rising edges of the divided tick.
// Optional lap capture registers are built when TICK_BCD_TIMER_LAP_EN is defined.
module tick_bcd_timer #(
  parameter int unsigned TENS_MAX = 9
) (
  input logic          clk_in,
  input logic          rst,
  tick_bcd_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] TENS_LAST = 4'(TENS_MAX);

  state_t     state_q;
  state_t     state_d;
  logic       tick_d;
  logic       tick_edge;
  logic       count_en;
  logic [3:0] ones_q;
  logic [3:0] tens_q;
  logic       wrap_q;

  assign tick_edge = bus.tick_in & ~tick_d;
  // Stop and Clear in the same cycle as an edge swallow it; Start never counts its own edge.
  assign count_en  = (state_q == RUN) & tick_edge & ~bus.stop & ~bus.clear;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      tick_d <= 1'b0;
    end else begin
      tick_d <= bus.tick_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.clear) begin
      state_d = IDLE;
    end else if (bus.stop) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else if (bus.start) begin
      if (state_q != RUN) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst || bus.clear) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (count_en) begin
        if (ones_q >= 4'd9) begin
          ones_q <= 4'd0;
          if (tens_q >= TENS_LAST) begin
            tens_q <= 4'd0;
            wrap_q <= 1'b1;
          end else begin
            tens_q <= tens_q + 4'd1;
          end
        end else begin
          ones_q <= ones_q + 4'd1;
        end
      end
    end
  end

  assign bus.bcd_ones = ones_q;
  assign bus.bcd_tens = tens_q;
  assign bus.wrap     = wrap_q;
  assign bus.running  = (state_q == RUN);

`ifdef TICK_BCD_TIMER_LAP_EN
  logic [3:0] lap_ones_q;
  logic [3:0] lap_tens_q;

  // Lap snapshots the digits as they stood before this cycle's increment.
  always_ff @(posedge clk_in) begin
    if (rst || bus.clear) begin
      lap_ones_q <= 4'd0;
      lap_tens_q <= 4'd0;
    end else if (bus.lap) begin
      lap_ones_q <= ones_q;
      lap_tens_q <= tens_q;
    end
  end

  assign bus.lap_ones = lap_ones_q;
  assign bus.lap_tens = lap_tens_q;
`endif

endmodule

// File: tb/tb_tick_bcd_timer.sv
// Self-checking bench for tick_bcd_timer: directed vector table, wrap sequences
// on TENS_MAX=9 and TENS_MAX=2 instances, and randomized traffic against a count model.
module tb_tick_bcd_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s   = 1'b1;
  logic tick_s  = 1'b0;
  logic start_s = 1'b0;
  logic stop_s  = 1'b0;
  logic clear_s = 1'b0;
  logic lap_s   = 1'b0;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  tick_bcd_timer_if if9 ();
  tick_bcd_timer_if if2 ();

  assign if9.tick_in = tick_s;
  assign if9.start   = start_s;
  assign if9.stop    = stop_s;
  assign if9.clear   = clear_s;
  assign if2.tick_in = tick_s;
  assign if2.start   = start_s;
  assign if2.stop    = stop_s;
  assign if2.clear   = clear_s;
`ifdef TICK_BCD_TIMER_LAP_EN
  assign if9.lap = lap_s;
  assign if2.lap = lap_s;
`endif

  tick_bcd_timer #(.TENS_MAX(9)) dut9 (.clk_in(clk), .rst(rst_s), .bus(if9.slave));
  tick_bcd_timer #(.TENS_MAX(2)) dut2 (.clk_in(clk), .rst(rst_s), .bus(if2.slave));

  task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference: the count is one integer modulo (TENS_MAX+1)*10, mode is idle/run/pause.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
  int   m_cnt[2]  = '{0, 0};
  int   m_mode[2] = '{M_IDLE, M_IDLE};
  bit   m_wrap[2] = '{1'b0, 1'b0};
  int   m_lap[2]  = '{0, 0};
  logic m_tick_prev = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int span;
      bit rise;
      span = (k == 0) ? 100 : 30;
      rise = tick_s && !m_tick_prev;
      if (rst_s) begin
        m_cnt[k] = 0; m_mode[k] = M_IDLE; m_wrap[k] = 1'b0; m_lap[k] = 0;
      end else begin
        m_wrap[k] = 1'b0;
        if (lap_s) m_lap[k] = m_cnt[k];
        if (clear_s) begin
          m_cnt[k] = 0; m_mode[k] = M_IDLE; m_lap[k] = 0;
        end else begin
          if (m_mode[k] == M_RUN && rise && !stop_s) begin
            m_cnt[k] = (m_cnt[k] + 1) % span;
            m_wrap[k] = (m_cnt[k] == 0);
          end
          if (stop_s) begin
            if (m_mode[k] == M_RUN) m_mode[k] = M_PAUSE;
          end else if (start_s) begin
            m_mode[k] = M_RUN;
          end
        end
      end
    end
    m_tick_prev = rst_s ? 1'b0 : tick_s;
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model9_ones", 8'(if9.bcd_ones), 8'(m_cnt[0] % 10));
      checkOutput("model9_tens", 8'(if9.bcd_tens), 8'(m_cnt[0] / 10));
      checkOutput("model9_running", 8'(if9.running), 8'(m_mode[0] == M_RUN));
      checkOutput("model9_wrap", 8'(if9.wrap), 8'(m_wrap[0]));
      checkOutput("model2_ones", 8'(if2.bcd_ones), 8'(m_cnt[1] % 10));
      checkOutput("model2_tens", 8'(if2.bcd_tens), 8'(m_cnt[1] / 10));
      checkOutput("model2_running", 8'(if2.running), 8'(m_mode[1] == M_RUN));
      checkOutput("model2_wrap", 8'(if2.wrap), 8'(m_wrap[1]));
`ifdef TICK_BCD_TIMER_LAP_EN
      checkOutput("model9_lap_ones", 8'(if9.lap_ones), 8'(m_lap[0] % 10));
      checkOutput("model9_lap_tens", 8'(if9.lap_tens), 8'(m_lap[0] / 10));
      checkOutput("model2_lap_ones", 8'(if2.lap_ones), 8'(m_lap[1] % 10));
      checkOutput("model2_lap_tens", 8'(if2.lap_tens), 8'(m_lap[1] / 10));
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic t, input logic sa,
                               input logic so, input logic cl);
    @(negedge clk);
    rst_s = r; tick_s = t; start_s = sa; stop_s = so; clear_s = cl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic r, t, sa, so, cl;
    int   ones, tens;
    logic run, wr;
    string nm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic r, logic t, logic sa, logic so, logic cl,
                               int ones, int tens, logic run, logic wr, string nm);
    vec_t v;
    v.r = r; v.t = t; v.sa = sa; v.so = so; v.cl = cl;
    v.ones = ones; v.tens = tens; v.run = run; v.wr = wr; v.nm = nm;
    return v;
  endfunction

  initial begin
    int hold;

    vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, "rst_a"));
    vecs.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_b"));
    vecs.push_back(mkv(1, 1, 0, 0, 0, 0, 0, 0, 0, "rst_c"));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 0, 0, 0, 0, "edge_idle"));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 1, 0, "start"));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 0, 1, 0, "edge1"));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 1, 0, 1, 0, "low1"));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 2, 0, 1, 0, "edge2"));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 2, 0, 1, 0, "low2"));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 3, 0, 1, 0, "edge3"));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 3, 0, 0, 0, "stop"));
    vecs.push_back(mkv(0, 1, 1, 0, 0, 3, 0, 1, 0, "start_with_edge"));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 3, 0, 1, 0, "low3"));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 4, 0, 1, 0, "edge4"));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 4, 0, 1, 0, "low4"));
    vecs.push_back(mkv(0, 1, 0, 1, 0, 4, 0, 0, 0, "stop_with_edge"));
    vecs.push_back(mkv(0, 0, 0, 1, 0, 4, 0, 0, 0, "stop_in_pause"));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 4, 0, 1, 0, "resume"));
    vecs.push_back(mkv(0, 1, 1, 0, 0, 5, 0, 1, 0, "start_in_run"));
    vecs.push_back(mkv(0, 0, 1, 1, 1, 0, 0, 0, 0, "clear_priority"));
    vecs.push_back(mkv(0, 1, 1, 0, 0, 0, 0, 1, 0, "start_edge_idle"));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 1, 0, "low5"));
    vecs.push_back(mkv(0, 1, 0, 0, 0, 1, 0, 1, 0, "edge5"));
    vecs.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, 0, "rst_midcount"));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, "after_rst"));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].t, vecs[i].sa, vecs[i].so, vecs[i].cl);
      check_en = 1'b1;
      checkOutput({vecs[i].nm, "_ones"}, 8'(if9.bcd_ones), 8'(vecs[i].ones));
      checkOutput({vecs[i].nm, "_tens"}, 8'(if9.bcd_tens), 8'(vecs[i].tens));
      checkOutput({vecs[i].nm, "_running"}, 8'(if9.running), 8'(vecs[i].run));
      checkOutput({vecs[i].nm, "_wrap"}, 8'(if9.wrap), 8'(vecs[i].wr));
    end

    // Full rollover: 99 -> 00 on the wide instance, 29 -> 00 on the narrow one.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    for (int e = 1; e <= 100; e++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (e == 99) begin
        checkOutput("w9_at99_ones", 8'(if9.bcd_ones), 8'd9);
        checkOutput("w9_at99_tens", 8'(if9.bcd_tens), 8'd9);
        checkOutput("w9_at99_wrap", 8'(if9.wrap), 8'd0);
      end
      if (e == 100) begin
        checkOutput("w9_roll_ones", 8'(if9.bcd_ones), 8'd0);
        checkOutput("w9_roll_tens", 8'(if9.bcd_tens), 8'd0);
        checkOutput("w9_roll_wrap", 8'(if9.wrap), 8'd1);
      end
      if (e == 29) begin
        checkOutput("w2_at29_tens", 8'(if2.bcd_tens), 8'd2);
        checkOutput("w2_at29_wrap", 8'(if2.wrap), 8'd0);
      end
      if (e == 30) begin
        checkOutput("w2_roll_ones", 8'(if2.bcd_ones), 8'd0);
        checkOutput("w2_roll_tens", 8'(if2.bcd_tens), 8'd0);
        checkOutput("w2_roll_wrap", 8'(if2.wrap), 8'd1);
      end
      applyStimulus(0, 0, 0, 0, 0);
      if (e == 100) checkOutput("w9_wrap_one_cycle", 8'(if9.wrap), 8'd0);
      if (e == 30) checkOutput("w2_wrap_one_cycle", 8'(if2.wrap), 8'd0);
    end

`ifdef TICK_BCD_TIMER_LAP_EN
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    for (int e = 1; e <= 12; e++) begin
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end
    @(negedge clk); lap_s = 1'b1; tick_s = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); lap_s = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("lap_ones", 8'(if9.lap_ones), 8'd2);
    checkOutput("lap_tens", 8'(if9.lap_tens), 8'd1);
    checkOutput("lap_count_moves", 8'(if9.bcd_ones), 8'd4);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("lap_clear_ones", 8'(if9.lap_ones), 8'd0);
    checkOutput("lap_clear_tens", 8'(if9.lap_tens), 8'd0);
`endif

    // Randomized traffic; the negedge model comparison does the checking.
    hold = 1;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      hold--;
      if (hold <= 0) begin
        tick_s = ~tick_s;
        hold = $urandom_range(1, 4);
      end
      start_s = ($urandom_range(0, 5) == 0);
      stop_s  = ($urandom_range(0, 29) == 0);
      clear_s = ($urandom_range(0, 299) == 0);
      rst_s   = ($urandom_range(0, 1499) == 0);
      lap_s   = ($urandom_range(0, 9) == 0);
    end
    @(negedge clk);
    rst_s = 1'b0; start_s = 1'b0; stop_s = 1'b0; clear_s = 1'b0; lap_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
